ysyx_23060240_clint: RTL and testbench
======================================

Name: ysyx_23060240_clint

Overview:
- Core-local timer (CLINT) implemented as an AXI4-Lite slave.
- Sits downstream of the IFU/LSU arbiter, alongside the SRAM slave, on the same saxi_* channel set. The arbiter or address decode steers LSU accesses in the CLINT window here.
- Holds a free-running 64-bit mtime counter and a 64-bit mtimecmp register.
- Raises a level timer interrupt for the CSR unit when mtime >= mtimecmp.

Parameters:
BASE_ADDR, 32'h0200_0000, window base; bits [31:4] decoded, bits [3:2] select register
PRESCALE, 16'd1, clk cycles per mtime tick (legal range 1..65535)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
saxi_araddr  in  32  read address
saxi_arvalid  in  1  read address valid
saxi_arready  out  1  read address ready
saxi_rdata  out  32  read data
saxi_rvalid  out  1  read data valid
saxi_rready  in  1  read data ready
saxi_awaddr  in  32  write address
saxi_awvalid  in  1  write address valid
saxi_awready  out  1  write address ready
saxi_wdata  in  32  write data
saxi_wstrb  in  4  write byte enables
saxi_wvalid  in  1  write data valid
saxi_wready  out  1  write data ready
saxi_bvalid  out  1  write response valid
saxi_bready  in  1  write response ready
timer_irq  out  1  registered, mtime >= mtimecmp

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x0: mtime[31:0]
  - 0x4: mtime[63:32]
  - 0x8: mtimecmp[31:0]
  - 0xC: mtimecmp[63:32]
- Address outside the window (addr[31:4] != BASE_ADDR[31:4]): reads return 32'h0, writes are dropped but still get bvalid. No error response exists on this bus.
- Reset (rst low, async):
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, prescaler = 0, snapshot = 0.
  - Read FSM = R_IDLE, write FSM = W_IDLE.
  - Outputs: arready = 1, awready = 1, wready = 1, rvalid = 0, bvalid = 0, rdata = 0, timer_irq = 0.
- Prescaler:
  - 16-bit counter; when it equals PRESCALE-1 it returns to 0 and mtime += 1.
  - mtime wraps from 2^64-1 to 0 with no flag.
- Read FSM:
  - R_IDLE: arready = 1. On arvalid & arready, latch the decoded data into rdata and go to R_DATA. rvalid rises the next cycle (1-cycle latency).
  - R_DATA: arready = 0, rvalid = 1, rdata held stable. On rready, go to R_IDLE. Back-to-back reads sustain one read per 2 cycles.
- Read coherence:
  - A read of 0x0 captures the full 64-bit mtime into a snapshot register in the same cycle.
  - A read of 0x4 returns snapshot[63:32], not live mtime[63:32].
  - Software reads lo then hi and always gets a consistent pair.
- Write FSM (AW and W accepted independently, in either order or the same cycle):
  - W_IDLE: awready = !aw_held, wready = !w_held. Each handshake latches its payload and sets its held flag.
  - When both are held (including the cycle both arrive together), apply the write next edge, clear both flags, go to W_RESP.
  - W_RESP: awready = wready = 0, bvalid = 1. On bready, go to W_IDLE.
- Write data: wstrb byte lanes are merged into the target 32-bit half; wstrb = 0 leaves the register unchanged but still responds.
- Simultaneous write to mtime (either half) and a prescaler tick: the write wins, the tick is lost, and the prescaler resets to 0.
- Read and write channels are independent. A read in the same cycle as a write to the same register returns the pre-write value.
- timer_irq is registered from (mtime >= mtimecmp) using post-update values; it lags the compare by 1 cycle. Writing mtimecmp above mtime deasserts it one cycle after the write commits.
- Async reset mid-transaction aborts it: pending AW/W are discarded and valid outputs drop immediately.

Decomposition:
- Shared package ysyx_23060240_clint_pkg:
  - offset constants CLINT_MTIME_LO/HI, CLINT_MTIMECMP_LO/HI
  - read FSM enum {R_IDLE, R_DATA}
  - write FSM enum {W_IDLE, W_RESP}
- One sub-module, ysyx_23060240_clint_timer: prescaler, 64-bit mtime with 32-bit-half write-merge ports, and the irq compare register.
- The top holds the AXI FSMs and decode.

Test Plan:
- Reset, then idle 10 cycles with PRESCALE=1 -> read 0x0 returns 10±1 (exact per bench alignment); read 0x4 returns 0; timer_irq = 0.
- Write 0x0 = 32'hFFFF_FFFE, 0x4 = 32'h0 (AW one cycle before W), then wait 3 ticks -> read lo/hi gives 0x0000_0001 / 0x0000_0001. Confirms carry into hi and snapshot coherence.
- Write mtimecmp = 20 with mtime near 15 -> timer_irq rises exactly 1 cycle after mtime reaches 20. Then write mtimecmp_hi = 1 -> irq drops 1 cycle after bvalid.
- Hold rready = 0 for 5 cycles after an AR -> rvalid and rdata stay stable, arready stays 0, a second arvalid is not accepted until rready.
- Write to BASE+0x10 with wstrb = 4'hF, and write to 0x8 with wstrb = 4'b0010 and data 32'h0000_AB00 -> first gives bvalid with no state change; second sets only mtimecmp[15:8] = 8'hAB.
- Assert rst low while in R_DATA and with AW held -> rvalid = 0 and held AW cleared immediately; after release, a fresh W-before-AW write completes normally.

Source files
------------

// File: rtl/ysyx_23060240_clint_pkg.sv
// Shared definitions for the core-local timer: register offsets, FSM states, helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ysyx_23060240_clint_pkg;

    // Byte offsets of the four 32-bit registers inside the 16-byte window
    localparam logic [3:0] CLINT_MTIME_LO    = 4'h0;
    localparam logic [3:0] CLINT_MTIME_HI    = 4'h4;
    localparam logic [3:0] CLINT_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] CLINT_MTIMECMP_HI = 4'hC;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    // Replace only the byte lanes enabled in strb
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Register offset of an address, word aligned
    function automatic logic [3:0] reg_offset(input logic [1:0] sel);
        return {sel, 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_23060240_clint_timer.sv
// Prescaled 64-bit mtime counter, mtimecmp register and registered compare interrupt.
// Latency: writes land on the next edge; irq reflects the compare one cycle later.
// Backpressure: none, write enables are single-cycle strobes from the bus front end.
module ysyx_23060240_clint_timer
    import ysyx_23060240_clint_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtime_lo_we,
    input  logic        mtime_hi_we,
    input  logic        mtimecmp_lo_we,
    input  logic        mtimecmp_hi_we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        irq
);

    localparam logic [15:0] PRESC_MAX = PRESCALE - 16'd1;

    logic [15:0] presc;
    logic        tick;
    logic        mtime_we;

    assign tick     = (presc == PRESC_MAX);
    assign mtime_we = mtime_lo_we | mtime_hi_we;

    // Prescaler: a software write to mtime restarts the tick phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= 16'd0;
        end else if (mtime_we || tick) begin
            presc <= 16'd0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // mtime: a bus write takes priority and swallows a coincident tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime <= 64'd0;
        end else if (mtime_lo_we) begin
            mtime <= {mtime[63:32], strb_merge(mtime[31:0], wdata, wstrb)};
        end else if (mtime_hi_we) begin
            mtime <= {strb_merge(mtime[63:32], wdata, wstrb), mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp: resets to all ones so the interrupt stays quiet until programmed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (mtimecmp_lo_we) begin
            mtimecmp <= {mtimecmp[63:32], strb_merge(mtimecmp[31:0], wdata, wstrb)};
        end else if (mtimecmp_hi_we) begin
            mtimecmp <= {strb_merge(mtimecmp[63:32], wdata, wstrb), mtimecmp[31:0]};
        end
    end

    // Level interrupt registered from the current register values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/ysyx_23060240_clint.sv
// CLINT AXI4-Lite slave: address decode, read/write channel FSMs around the timer core.
// Latency: read data one cycle after AR accept; write response one cycle after AW+W both held.
// Backpressure: arready low while read data is pending; aw/wready low once held or while bvalid.
module ysyx_23060240_clint
    import ysyx_23060240_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter logic [15:0] PRESCALE  = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] saxi_araddr,
    input  logic        saxi_arvalid,
    output logic        saxi_arready,
    output logic [31:0] saxi_rdata,
    output logic        saxi_rvalid,
    input  logic        saxi_rready,
    input  logic [31:0] saxi_awaddr,
    input  logic        saxi_awvalid,
    output logic        saxi_awready,
    input  logic [31:0] saxi_wdata,
    input  logic [3:0]  saxi_wstrb,
    input  logic        saxi_wvalid,
    output logic        saxi_wready,
    output logic        saxi_bvalid,
    input  logic        saxi_bready,
    output logic        timer_irq
);

    rd_state_e   r_state, r_next;
    wr_state_e   w_state, w_next;

    logic [63:0] mtime, mtimecmp, snapshot;
    logic [31:0] rd_dec;
    logic        ar_fire, ar_hit;

    logic        aw_held, w_held;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_fire, w_fire, commit;
    logic [31:0] eff_addr, eff_data;
    logic [3:0]  eff_strb;
    logic        wr_hit;
    logic        unused_addr_bits;

    // Sub-word address bits carry no meaning on this 32-bit register file
    assign unused_addr_bits = ^{saxi_araddr[1:0], awaddr_q[1:0], saxi_awaddr[1:0]};

    // ---------------- read channel ----------------

    // Read FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (saxi_arvalid) r_next = R_DATA;
            R_DATA:  if (saxi_rready)  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        saxi_arready = (r_state == R_IDLE);
        saxi_rvalid  = (r_state == R_DATA);
    end

    assign ar_fire = saxi_arvalid & saxi_arready;
    assign ar_hit  = (saxi_araddr[31:4] == BASE_ADDR[31:4]);

    // Read decode; the high mtime half comes from the snapshot taken on the low read
    always_comb begin
        rd_dec = 32'd0;
        if (ar_hit) begin
            case (reg_offset(saxi_araddr[3:2]))
                CLINT_MTIME_LO:    rd_dec = mtime[31:0];
                CLINT_MTIME_HI:    rd_dec = snapshot[63:32];
                CLINT_MTIMECMP_LO: rd_dec = mtimecmp[31:0];
                CLINT_MTIMECMP_HI: rd_dec = mtimecmp[63:32];
                default:           rd_dec = 32'd0;
            endcase
        end
    end

    // Read data and snapshot capture on AR acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            saxi_rdata <= 32'd0;
            snapshot   <= 64'd0;
        end else if (ar_fire) begin
            saxi_rdata <= rd_dec;
            if (ar_hit && reg_offset(saxi_araddr[3:2]) == CLINT_MTIME_LO) begin
                snapshot <= mtime;
            end
        end
    end

    // ---------------- write channel ----------------

    // Write FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM next state
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (commit)      w_next = W_RESP;
            W_RESP:  if (saxi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs; each channel stops accepting once its beat is held
    always_comb begin
        saxi_awready = (w_state == W_IDLE) && !aw_held;
        saxi_wready  = (w_state == W_IDLE) && !w_held;
        saxi_bvalid  = (w_state == W_RESP);
    end

    // Commit as soon as both beats are available, held or arriving this cycle
    always_comb begin
        aw_fire  = saxi_awvalid & saxi_awready;
        w_fire   = saxi_wvalid & saxi_wready;
        commit   = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
        eff_addr = aw_held ? awaddr_q : saxi_awaddr;
        eff_data = w_held  ? wdata_q  : saxi_wdata;
        eff_strb = w_held  ? wstrb_q  : saxi_wstrb;
        wr_hit   = commit && (eff_addr[31:4] == BASE_ADDR[31:4]) && (eff_strb != 4'd0);
    end

    // Held AW/W payloads and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= 32'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
        end else begin
            if (aw_fire) awaddr_q <= saxi_awaddr;
            if (w_fire) begin
                wdata_q <= saxi_wdata;
                wstrb_q <= saxi_wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) aw_held <= 1'b1;
                if (w_fire)  w_held  <= 1'b1;
            end
        end
    end

    ysyx_23060240_clint_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .mtime_lo_we    (wr_hit && reg_offset(eff_addr[3:2]) == CLINT_MTIME_LO),
        .mtime_hi_we    (wr_hit && reg_offset(eff_addr[3:2]) == CLINT_MTIME_HI),
        .mtimecmp_lo_we (wr_hit && reg_offset(eff_addr[3:2]) == CLINT_MTIMECMP_LO),
        .mtimecmp_hi_we (wr_hit && reg_offset(eff_addr[3:2]) == CLINT_MTIMECMP_HI),
        .wdata          (eff_data),
        .wstrb          (eff_strb),
        .mtime          (mtime),
        .mtimecmp       (mtimecmp),
        .irq            (timer_irq)
    );

endmodule

// File: tb/tb_ysyx_23060240_clint.sv
// Self-checking bench for the CLINT slave: directed table, corner sequences, random ops.
// Latency: reference model predicts mtime as base + elapsed edges since last write/reset.
// Backpressure: random rready/bready stalls and all three AW/W arrival orders.
module tb_ysyx_23060240_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] saxi_araddr, saxi_rdata, saxi_awaddr, saxi_wdata;
    logic        saxi_arvalid, saxi_arready, saxi_rvalid, saxi_rready;
    logic        saxi_awvalid, saxi_awready, saxi_wvalid, saxi_wready;
    logic        saxi_bvalid, saxi_bready, timer_irq;
    logic [3:0]  saxi_wstrb;

    ysyx_23060240_clint #(.BASE_ADDR(BASE), .PRESCALE(16'd1)) dut (
        .clk(clk), .rst(rst),
        .saxi_araddr(saxi_araddr), .saxi_arvalid(saxi_arvalid), .saxi_arready(saxi_arready),
        .saxi_rdata(saxi_rdata), .saxi_rvalid(saxi_rvalid), .saxi_rready(saxi_rready),
        .saxi_awaddr(saxi_awaddr), .saxi_awvalid(saxi_awvalid), .saxi_awready(saxi_awready),
        .saxi_wdata(saxi_wdata), .saxi_wstrb(saxi_wstrb), .saxi_wvalid(saxi_wvalid),
        .saxi_wready(saxi_wready), .saxi_bvalid(saxi_bvalid), .saxi_bready(saxi_bready),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: mtime advances one per edge since the last write or reset release
    logic [63:0] base_val, cmp_m, snap_m;
    int          edges = 0;
    int          base_edge = 0;
    bit          track = 1'b0;

    function automatic logic [63:0] mt_now();
        return base_val + 64'(edges - base_edge);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) == BASE;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock edge; irq must equal the compare of the values held before that edge
    task automatic tick();
        logic [63:0] m, c;
        m = mt_now();
        c = cmp_m;
        @(posedge clk);
        edges++;
        #1;
        if (track) check("irq_track", {63'd0, timer_irq}, {63'd0, m >= c});
    endtask

    task automatic model_reset();
        base_val  = 64'd0;
        base_edge = edges;
        cmp_m     = 64'hFFFF_FFFF_FFFF_FFFF;
        snap_m    = 64'd0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdly, output logic [31:0] got);
        logic [31:0] exp;
        logic [63:0] now;
        int n;
        saxi_araddr  = addr;
        saxi_arvalid = 1'b1;
        n = 0;
        while (!saxi_arready && n < 20) begin tick(); n++; end
        check("ar_accept", {63'd0, saxi_arready}, 64'd1);
        now = mt_now();
        exp = 32'd0;
        if (in_win(addr)) begin
            case (addr[3:2])
                2'd0: begin exp = now[31:0]; snap_m = now; end
                2'd1: exp = snap_m[63:32];
                2'd2: exp = cmp_m[31:0];
                default: exp = cmp_m[63:32];
            endcase
        end
        tick();
        saxi_arvalid = 1'b0;
        n = 0;
        while (!saxi_rvalid && n < 20) begin tick(); n++; end
        check("rvalid_up", {63'd0, saxi_rvalid}, 64'd1);
        for (int i = 0; i < rdly; i++) tick();
        got = saxi_rdata;
        check("rdata", {32'd0, got}, {32'd0, exp});
        saxi_rready = 1'b1;
        tick();
        saxi_rready = 1'b0;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int order, input int bdly);
        logic [63:0] pre;
        int n;
        saxi_awaddr = addr;
        saxi_wdata  = data;
        saxi_wstrb  = strb;
        if (order == 1) begin
            saxi_awvalid = 1'b1;
            n = 0;
            while (!saxi_awready && n < 20) begin tick(); n++; end
            tick();
            saxi_awvalid = 1'b0;
            saxi_wvalid  = 1'b1;
        end else if (order == 2) begin
            saxi_wvalid = 1'b1;
            n = 0;
            while (!saxi_wready && n < 20) begin tick(); n++; end
            tick();
            saxi_wvalid  = 1'b0;
            saxi_awvalid = 1'b1;
        end else begin
            saxi_awvalid = 1'b1;
            saxi_wvalid  = 1'b1;
        end
        n = 0;
        while (!((saxi_awready || !saxi_awvalid) && (saxi_wready || !saxi_wvalid)) && n < 20) begin
            tick(); n++;
        end
        check("aw_w_accept", {62'd0, saxi_awready | !saxi_awvalid, saxi_wready | !saxi_wvalid}, 64'd3);
        pre = mt_now();
        tick();
        saxi_awvalid = 1'b0;
        saxi_wvalid  = 1'b0;
        if (in_win(addr) && strb != 4'd0) begin
            case (addr[3:2])
                2'd0: begin base_val = {pre[63:32], merge(pre[31:0], data, strb)}; base_edge = edges; end
                2'd1: begin base_val = {merge(pre[63:32], data, strb), pre[31:0]}; base_edge = edges; end
                2'd2: cmp_m = {cmp_m[63:32], merge(cmp_m[31:0], data, strb)};
                default: cmp_m = {merge(cmp_m[63:32], data, strb), cmp_m[31:0]};
            endcase
        end
        n = 0;
        while (!saxi_bvalid && n < 20) begin tick(); n++; end
        check("bvalid", {63'd0, saxi_bvalid}, 64'd1);
        for (int i = 0; i < bdly; i++) tick();
        saxi_bready = 1'b1;
        tick();
        saxi_bready = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          order;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] lo, hi, got, e1;
        logic [63:0] e2;
        int n;

        tbl[0]  = '{0, BASE + 32'h8,  32'h0,         4'hF, 0, 32'hFFFF_FFFF};
        tbl[1]  = '{0, BASE + 32'hC,  32'h0,         4'hF, 0, 32'hFFFF_FFFF};
        tbl[2]  = '{1, BASE + 32'h8,  32'h1234_5678, 4'hF, 0, 32'h0};
        tbl[3]  = '{0, BASE + 32'h8,  32'h0,         4'hF, 0, 32'h1234_5678};
        tbl[4]  = '{1, BASE + 32'hC,  32'hA5A5_0000, 4'hC, 1, 32'h0};
        tbl[5]  = '{0, BASE + 32'hC,  32'h0,         4'hF, 0, 32'hA5A5_FFFF};
        tbl[6]  = '{1, BASE + 32'h8,  32'h0000_AB00, 4'h2, 2, 32'h0};
        tbl[7]  = '{0, BASE + 32'h8,  32'h0,         4'hF, 0, 32'h1234_AB78};
        tbl[8]  = '{1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0};
        tbl[9]  = '{0, BASE + 32'h8,  32'h0,         4'hF, 0, 32'h1234_AB78};
        tbl[10] = '{0, BASE + 32'h10, 32'h0,         4'hF, 0, 32'h0};
        tbl[11] = '{0, 32'h1000_0008, 32'h0,         4'hF, 0, 32'h0};
        tbl[12] = '{1, BASE + 32'h8,  32'hFFFF_FFFF, 4'h0, 1, 32'h0};
        tbl[13] = '{0, BASE + 32'h8,  32'h0,         4'hF, 0, 32'h1234_AB78};

        rst = 1'b0;
        saxi_araddr = 0; saxi_arvalid = 0; saxi_rready = 0;
        saxi_awaddr = 0; saxi_awvalid = 0; saxi_wdata = 0; saxi_wstrb = 0;
        saxi_wvalid = 0; saxi_bready = 0;
        model_reset();
        repeat (3) tick();
        check("rst_outs", {57'd0, saxi_arready, saxi_awready, saxi_wready, saxi_rvalid,
                           saxi_bvalid, timer_irq, |saxi_rdata}, {57'd0, 7'b1110000});
        rst = 1'b1;
        model_reset();
        track = 1'b1;

        // Free-running count from reset
        repeat (10) tick();
        do_read(BASE + 32'h0, 0, lo);
        do_read(BASE + 32'h4, 0, hi);
        check("idle10_lo", {32'd0, lo}, 64'd10);
        check("idle10_hi", {32'd0, hi}, 64'd0);
        check("idle10_irq", {63'd0, timer_irq}, 64'd0);

        // mtimecmp register map, byte strobes and out-of-window accesses
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].order, 0);
            else begin
                do_read(tbl[i].addr, 0, got);
                check($sformatf("tbl%0d", i), {32'd0, got}, {32'd0, tbl[i].exp});
            end
        end

        // Carry into the high half seen coherently through the snapshot
        do_write(BASE + 32'h4, 32'h0, 4'hF, 0, 0);
        do_write(BASE + 32'h0, 32'hFFFF_FFFE, 4'hF, 1, 0);
        tick();
        tick();
        do_read(BASE + 32'h0, 0, lo);
        do_read(BASE + 32'h4, 2, hi);
        check("carry_pair", {hi, lo}, 64'h0000_0001_0000_0001);

        // Interrupt rise at mtimecmp and fall after raising mtimecmp_hi
        do_write(BASE + 32'h4, 32'h0, 4'hF, 0, 0);
        do_write(BASE + 32'h0, 32'd10, 4'hF, 2, 0);
        do_write(BASE + 32'h8, 32'd20, 4'hF, 0, 0);
        do_write(BASE + 32'hC, 32'd0, 4'hF, 0, 0);
        check("irq_before", {63'd0, timer_irq}, 64'd0);
        n = 0;
        while (!timer_irq && n < 40) begin tick(); n++; end
        check("irq_rise_seen", {63'd0, timer_irq}, 64'd1);
        do_write(BASE + 32'hC, 32'd1, 4'hF, 0, 0);
        check("irq_fall", {63'd0, timer_irq}, 64'd0);

        // rready stall: data held, no second AR accepted until the first retires
        saxi_araddr  = BASE + 32'h8;
        saxi_arvalid = 1'b1;
        e1 = cmp_m[31:0];
        tick();
        saxi_araddr = BASE + 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {30'd0, saxi_rvalid, saxi_arready, saxi_rdata},
                  {30'd0, 2'b10, e1});
            tick();
        end
        saxi_rready = 1'b1;
        tick();
        saxi_rready = 1'b0;
        check("stall_ar_ready", {63'd0, saxi_arready}, 64'd1);
        e2 = mt_now();
        snap_m = e2;
        tick();
        saxi_arvalid = 1'b0;
        check("second_read", {31'd0, saxi_rvalid, saxi_rdata}, {31'd0, 1'b1, e2[31:0]});
        saxi_rready = 1'b1;
        tick();
        saxi_rready = 1'b0;

        // Random traffic against the model
        for (int it = 0; it < 60; it++) begin
            int r, sel;
            logic [31:0] a;
            r   = $urandom_range(0, 9);
            sel = $urandom_range(0, 5);
            a   = (sel < 4) ? BASE + 32'(sel * 4) : ((sel == 4) ? BASE + 32'h20 : 32'h8000_0004);
            if (r < 4) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                         $urandom_range(0, 3));
            end else if (r < 7) begin
                do_read(BASE + 32'h0, $urandom_range(0, 3), lo);
                do_read(BASE + 32'h4, $urandom_range(0, 3), hi);
            end else begin
                do_read(a, $urandom_range(0, 3), got);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset mid-transaction: pending read and held AW are abandoned
        saxi_araddr  = BASE + 32'h8;
        saxi_arvalid = 1'b1;
        tick();
        saxi_arvalid = 1'b0;
        saxi_awaddr  = BASE + 32'h0;
        saxi_awvalid = 1'b1;
        tick();
        saxi_awvalid = 1'b0;
        check("pre_rst_state", {61'd0, saxi_rvalid, saxi_awready, saxi_wready}, {61'd0, 3'b101});
        rst = 1'b0;
        track = 1'b0;
        #1;
        check("mid_rst_outs", {57'd0, saxi_arready, saxi_awready, saxi_wready, saxi_rvalid,
                               saxi_bvalid, timer_irq, |saxi_rdata}, {57'd0, 7'b1110000});
        tick();
        tick();
        rst = 1'b1;
        model_reset();
        track = 1'b1;
        do_write(BASE + 32'h8, 32'h0000_0042, 4'hF, 2, 1);
        do_read(BASE + 32'h8, 0, got);
        check("post_rst_write", {32'd0, got}, 64'h42);
        do_read(BASE + 32'hC, 0, got);
        check("post_rst_cmp_hi", {32'd0, got}, 64'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
